// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: shares one WIDTH-bit counter between two requesters.
// A round-robin arbiter grants one requester, which runs a bounded count
// in its latched mode. A done pulse is returned when the run completes.
// Ports:
//   clk            rising-edge clock
//   clear          asynchronous active-high reset
//   req[1:0]       level requests, held for the whole run
//   mode0/len0     requester 0 count mode / step count, sampled at grant
//   mode1/len1     requester 1 count mode / step count, sampled at grant
//   gnt[1:0]       one-hot grant (registered)
//   q[WIDTH-1:0]   counter value (registered)
//   busy           high whenever the controller is not idle
//   done[1:0]      one-cycle completion pulse to the granted requester
module count_seq_ctrl #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [1:0]       req,
  input  logic [1:0]       mode0,
  input  logic [WIDTH-1:0] len0,
  input  logic [1:0]       mode1,
  input  logic [WIDTH-1:0] len1,
  output logic [1:0]       gnt,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic [1:0]       done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_state_nx;
  logic             r_ptr,   w_ptr_nx;
  logic             r_sel,   w_sel_nx;
  logic [1:0]       r_mode,  w_mode_nx;
  logic [WIDTH-1:0] r_rem,   w_rem_nx;
  logic [1:0]       r_gnt,   w_gnt_nx;
  logic [WIDTH-1:0] r_q,     w_q_nx;
  logic [1:0]       r_done,  w_done_nx;
  logic             w_winner;
  logic [WIDTH-1:0] w_step;

  // Next Gray code: decode to binary, increment, re-encode.
  function automatic logic [WIDTH-1:0] f_gray_inc(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    b = b + WIDTH'(1);
    return b ^ (b >> 1);
  endfunction

  // Both requesting: the pointer decides; otherwise the lone requester wins.
  assign w_winner = (req == 2'b11) ? r_ptr : req[1];

  // One counter step in the latched mode; mode 11 behaves as binary up.
  always_comb begin
    case (r_mode)
      2'b01:   w_step = r_q - WIDTH'(1);
      2'b10:   w_step = f_gray_inc(r_q);
      default: w_step = r_q + WIDTH'(1);
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_sel_nx   = r_sel;
    w_mode_nx  = r_mode;
    w_rem_nx   = r_rem;
    w_gnt_nx   = r_gnt;
    w_q_nx     = r_q;
    w_done_nx  = 2'b00;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_sel_nx   = w_winner;
          w_mode_nx  = w_winner ? mode1 : mode0;
          // A length of 0 wraps through the decrement to a full 2^WIDTH run.
          w_rem_nx   = w_winner ? len1 : len0;
          w_q_nx     = '0;
          w_gnt_nx   = w_winner ? 2'b10 : 2'b01;
          w_state_nx = RUN;
        end
      end
      RUN: begin
        if (!req[r_sel]) begin
          // Abort: q freezes, no done pulse, pointer passes on.
          w_gnt_nx   = 2'b00;
          w_ptr_nx   = ~r_sel;
          w_state_nx = IDLE;
        end else begin
          w_q_nx   = w_step;
          w_rem_nx = r_rem - WIDTH'(1);
          if (r_rem == WIDTH'(1)) begin
            w_done_nx  = r_gnt;
            w_state_nx = DONE;
          end
        end
      end
      DONE: begin
        w_gnt_nx   = 2'b00;
        w_ptr_nx   = ~r_sel;
        w_state_nx = IDLE;
      end
      default: begin
        w_gnt_nx   = 2'b00;
        w_state_nx = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_sel   <= 1'b0;
      r_mode  <= 2'b00;
      r_rem   <= '0;
      r_gnt   <= 2'b00;
      r_q     <= '0;
      r_done  <= 2'b00;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_sel   <= w_sel_nx;
      r_mode  <= w_mode_nx;
      r_rem   <= w_rem_nx;
      r_gnt   <= w_gnt_nx;
      r_q     <= w_q_nx;
      r_done  <= w_done_nx;
    end
  end

  assign gnt  = r_gnt;
  assign q    = r_q;
  assign done = r_done;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Self-checking bench for count_seq_ctrl (WIDTH = 3).
module tb_count_seq_ctrl;

  logic       clk;
  logic       clear;
  logic [1:0] req;
  logic [1:0] mode0, mode1;
  logic [2:0] len0, len1;
  logic [1:0] gnt;
  logic [2:0] q;
  logic       busy;
  logic [1:0] done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] q_exp[$];
  logic [1:0] gnt_exp[$];
  logic [1:0] done_exp[$];

  count_seq_ctrl #(.WIDTH(3)) dut (
    .clk   (clk),
    .clear (clear),
    .req   (req),
    .mode0 (mode0),
    .len0  (len0),
    .mode1 (mode1),
    .len1  (len1),
    .gnt   (gnt),
    .q     (q),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full run from one requester; expected q sequence queued up front.
  task automatic run_check(input bit r, input logic [1:0] m, input logic [2:0] l);
    int steps;
    int kk;
    int gnt_cycles;
    logic [2:0] e;
    logic [2:0] last;
    logic [1:0] oh;
    oh    = r ? 2'b10 : 2'b01;
    steps = (l == 3'd0) ? 8 : int'(l);
    gnt_cycles = 0;
    last = 3'd0;
    for (int k = 0; k <= steps; k++) begin
      kk = k % 8;
      case (m)
        2'b01:   e = 3'((8 - kk) % 8);
        2'b10:   e = 3'(kk ^ (kk >> 1));
        default: e = 3'(kk);
      endcase
      q_exp.push_back(e);
    end
    if (r) begin mode1 = m; len1 = l; end
    else   begin mode0 = m; len0 = l; end
    req = oh;
    tick();
    n_checks++;
    if (gnt !== oh || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL run_grant: gnt=%b busy=%b, expected gnt=%b busy=1", gnt, busy, oh);
    end
    // Inputs changing mid-run must not affect the run.
    if (r) begin mode1 = ~m; len1 = l + 3'd3; end
    else   begin mode0 = ~m; len0 = l + 3'd3; end
    for (int k = 0; k <= steps; k++) begin
      last = q_exp.pop_front();
      n_checks++;
      if (q !== last) begin
        n_fail++;
        $display("FAIL run_q step %0d: q=%0d, expected %0d", k, q, last);
      end
      n_checks++;
      if (done !== ((k == steps) ? oh : 2'b00)) begin
        n_fail++;
        $display("FAIL run_done step %0d: done=%b, expected %b", k, done,
                 (k == steps) ? oh : 2'b00);
      end
      if (gnt === oh) gnt_cycles++;
      if (k < steps) tick();
    end
    n_checks++;
    if (gnt_cycles != steps + 1) begin
      n_fail++;
      $display("FAIL run_gnt_cycles: %0d, expected %0d", gnt_cycles, steps + 1);
    end
    req = 2'b00;
    tick();
    n_checks++;
    if (gnt !== 2'b00 || busy !== 1'b0 || done !== 2'b00 || q !== last) begin
      n_fail++;
      $display("FAIL run_end: gnt=%b busy=%b done=%b q=%0d, expected 00 0 00 %0d",
               gnt, busy, done, q, last);
    end
    tick();
    n_checks++;
    if (q !== last || gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL run_hold: q=%0d gnt=%b, expected q=%0d gnt=00", q, gnt, last);
    end
  endtask

  task automatic test_reset();
    clear = 1'b1; req = 2'b00;
    mode0 = 2'b00; len0 = 3'd0; mode1 = 2'b00; len1 = 3'd0;
    #12;
    n_checks++;
    if (q !== 3'd0 || gnt !== 2'b00 || done !== 2'b00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: q=%0d gnt=%b done=%b busy=%b, expected all 0", q, gnt, done, busy);
    end
    @(negedge clk);
    clear = 1'b0;
    // Start an up run of 6 and clear it after 3 steps with no clock edge.
    mode0 = 2'b00; len0 = 3'd6; req = 2'b01;
    for (int k = 0; k < 4; k++) tick();
    n_checks++;
    if (q !== 3'd3 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prerun: q=%0d busy=%b, expected q=3 busy=1", q, busy);
    end
    #1 clear = 1'b1;
    #1;
    n_checks++;
    if (q !== 3'd0 || gnt !== 2'b00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: q=%0d gnt=%b busy=%b, expected 0 00 0", q, gnt, busy);
    end
    req = 2'b00;
    #1 clear = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (gnt !== 2'b00 || busy !== 1'b0 || q !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_quiet: gnt=%b busy=%b q=%0d, expected 00 0 0", gnt, busy, q);
      end
    end
  endtask

  task automatic test_up();     run_check(1'b0, 2'b00, 3'd5); endtask
  task automatic test_down();   run_check(1'b1, 2'b01, 3'd3); endtask
  task automatic test_gray();   run_check(1'b0, 2'b10, 3'd0); endtask
  task automatic test_mode11(); run_check(1'b1, 2'b11, 3'd7); endtask

  // Simultaneous requests alternate with one idle cycle between runs.
  task automatic test_back_to_back();
    logic [1:0] eg, ed;
    clear = 1'b1;
    #2 clear = 1'b0;
    mode0 = 2'b00; len0 = 3'd2; mode1 = 2'b00; len1 = 3'd2;
    gnt_exp  = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    done_exp = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    req = 2'b11;
    for (int k = 0; k < 9; k++) begin
      tick();
      eg = gnt_exp.pop_front();
      ed = done_exp.pop_front();
      n_checks++;
      if (gnt !== eg || done !== ed) begin
        n_fail++;
        $display("FAIL b2b cycle %0d: gnt=%b done=%b, expected gnt=%b done=%b", k, gnt, done, eg, ed);
      end
    end
    req = 2'b00;
    tick();
    tick();
    n_checks++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: gnt=%b busy=%b, expected 00 0", gnt, busy);
    end
  endtask

  // Dropping req mid-run freezes q, suppresses done, and passes the pointer.
  task automatic test_abort();
    logic saw_done;
    saw_done = 1'b0;
    clear = 1'b1;
    #2 clear = 1'b0;
    mode0 = 2'b00; len0 = 3'd6; req = 2'b01;
    q_exp = '{3'd0, 3'd1, 3'd2};
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done !== 2'b00) saw_done = 1'b1;
      n_checks++;
      if (q !== q_exp[0]) begin
        n_fail++;
        $display("FAIL abort_run q: %0d, expected %0d", q, q_exp[0]);
      end
      void'(q_exp.pop_front());
    end
    req = 2'b00;
    tick();
    n_checks++;
    if (gnt !== 2'b00 || busy !== 1'b0 || q !== 3'd2) begin
      n_fail++;
      $display("FAIL abort_stop: gnt=%b busy=%b q=%0d, expected 00 0 2", gnt, busy, q);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done !== 2'b00) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0 || q !== 3'd2) begin
      n_fail++;
      $display("FAIL abort_nodone: saw_done=%b q=%0d, expected 0 2", saw_done, q);
    end
    mode1 = 2'b00; len1 = 3'd4; req = 2'b11;
    tick();
    n_checks++;
    if (gnt !== 2'b10) begin
      n_fail++;
      $display("FAIL abort_next_grant: gnt=%b, expected 10", gnt);
    end
    req = 2'b00;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_up();
    test_down();
    test_gray();
    test_mode11();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
